// File: rtl/vec_alu_pipe.sv
// vec_alu_pipe: two-stage SIMD ALU (operand register, result register) with optional output skid register.
// Define VEC_ALU_SAT_EN for unsigned saturating ADD/SUB, selected by in_ppp[2] (the field's MSB-first bit 0).
module vec_alu_pipe #(
    parameter int DATA_W   = 64,
    parameter int OUT_SKID = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_func,
    input  logic [1:0]        in_ww,
    input  logic [4:0]        in_rd,
    input  logic [2:0]        in_ppp,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [4:0]        out_rd,
    output logic [2:0]        out_ppp,
    output logic              out_err
);
    logic              s1_v;
    logic [3:0]        s1_func;
    logic [1:0]        s1_ww;
    logic [4:0]        s1_rd;
    logic [2:0]        s1_ppp;
    logic [DATA_W-1:0] s1_a;
    logic [DATA_W-1:0] s1_b;
    logic              s2_v;
    logic              s2_err;
    logic [DATA_W-1:0] s2_data;
    logic [4:0]        s2_rd;
    logic [2:0]        s2_ppp;
    logic              sk_v;
    logic              sk_err;
    logic [DATA_W-1:0] sk_data;
    logic [4:0]        sk_rd;
    logic [2:0]        sk_ppp;
    logic              s1_free;
    logic              s2_free;
    logic              mul_op;
    logic              err;
    logic [DATA_W-1:0] res;
    logic [3:0][DATA_W-1:0] lane_res;
    logic [3:0][DATA_W-1:0] mul_res;
`ifdef VEC_ALU_SAT_EN
    logic              sat;
    assign sat = s1_ppp[2];
`endif

    // Per-width lane results; the final mux picks one row by s1_ww.
    for (genvar w = 0; w < 4; w++) begin : g_w
        localparam int W = 8 << w;
        localparam int S = 3 + w;
        for (genvar i = 0; i < DATA_W / W; i++) begin : g_l
            logic [W-1:0] a;
            logic [W-1:0] b;
            logic [W-1:0] sra;
            logic [W-1:0] add;
            logic [W-1:0] sub;
            logic [S-1:0] n;
            assign a   = s1_a[i*W +: W];
            assign b   = s1_b[i*W +: W];
            assign n   = s1_func[0] ? s1_b[S-1:0] : b[S-1:0];
            assign sra = $signed(a) >>> n;
`ifdef VEC_ALU_SAT_EN
            logic [W:0] s;
            logic [W:0] d;
            assign s   = {1'b0, a} + {1'b0, b};
            assign d   = {1'b0, a} - {1'b0, b};
            assign add = (sat && s[W]) ? '1 : s[W-1:0];
            assign sub = (sat && d[W]) ? '0 : d[W-1:0];
`else
            assign add = a + b;
            assign sub = a - b;
`endif
            assign lane_res[w][i*W +: W] = s1_func == 4'h5 ? add :
                                           s1_func == 4'h6 ? sub :
                                           s1_func == 4'h9 ? {a[W/2-1:0], a[W-1:W/2]} :
                                           s1_func[3:1] == 3'b101 ? a << n :
                                           s1_func[3:1] == 3'b110 ? a >> n : sra;
        end
    end

    // Even lane of a pair sits in the upper half of its double lane (lane 0 is most significant).
    for (genvar w = 0; w < 3; w++) begin : g_m
        localparam int W = 8 << w;
        for (genvar k = 0; k < DATA_W / (2 * W); k++) begin : g_k
            logic [2*W-1:0] x;
            logic [2*W-1:0] y;
            assign x = {{W{1'b0}}, s1_func[0] ? s1_a[k*2*W+W +: W] : s1_a[k*2*W +: W]};
            assign y = {{W{1'b0}}, s1_func[0] ? s1_b[k*2*W+W +: W] : s1_b[k*2*W +: W]};
            assign mul_res[w][k*2*W +: 2*W] = x * y;
        end
    end
    assign mul_res[3] = '0;

    assign mul_op = s1_func == 4'h7 || s1_func == 4'h8;
    assign err    = mul_op && s1_ww == 2'b11;
    assign res    = s1_func == 4'h0 ? s1_a & s1_b :
                    s1_func == 4'h1 ? s1_a | s1_b :
                    s1_func == 4'h2 ? s1_a ^ s1_b :
                    s1_func == 4'h3 ? ~s1_a :
                    s1_func == 4'h4 ? s1_a :
                    mul_op ? mul_res[s1_ww] : lane_res[s1_ww];

    // With a skid, a stalled result parks in the skid so stage 2 keeps flowing.
    assign s2_free   = !s2_v || (OUT_SKID != 0 ? !sk_v : out_ready);
    assign s1_free   = !s1_v || s2_free;
    assign in_ready  = !RST && s1_free;
    assign out_valid = sk_v || s2_v;
    assign out_data  = sk_v ? sk_data : s2_data;
    assign out_rd    = sk_v ? sk_rd : s2_rd;
    assign out_ppp   = sk_v ? sk_ppp : s2_ppp;
    assign out_err   = sk_v ? sk_err : s2_err;

    always_ff @(posedge CLK) begin
        if (RST) begin
            s1_v    <= 1'b0;
            s2_v    <= 1'b0;
            sk_v    <= 1'b0;
            s2_data <= '0;
            s2_rd   <= '0;
            s2_ppp  <= '0;
            s2_err  <= 1'b0;
            sk_data <= '0;
            sk_rd   <= '0;
            sk_ppp  <= '0;
            sk_err  <= 1'b0;
        end else begin
            if (s1_free) begin
                s1_v <= in_valid;
                if (in_valid) begin
                    s1_func <= in_func;
                    s1_ww   <= in_ww;
                    s1_rd   <= in_rd;
                    s1_ppp  <= in_ppp;
                    s1_a    <= in_a;
                    s1_b    <= in_b;
                end
            end
            if (s2_free) begin
                s2_v <= s1_v;
                if (s1_v) begin
                    s2_data <= res;
                    s2_rd   <= s1_rd;
                    s2_ppp  <= s1_ppp;
                    s2_err  <= err;
                end
            end
            if (sk_v) begin
                if (out_ready)
                    sk_v <= 1'b0;
            end else if (OUT_SKID != 0 && s2_v && !out_ready) begin
                sk_v    <= 1'b1;
                sk_data <= s2_data;
                sk_rd   <= s2_rd;
                sk_ppp  <= s2_ppp;
                sk_err  <= s2_err;
            end
        end
    end
endmodule

// File: tb/tb_vec_alu_pipe.sv
// tb_vec_alu_pipe: directed vectors for vec_alu_pipe with a queue scoreboard and independent output monitor.
module tb_vec_alu_pipe;
    logic        CLK = 1'b0;
    logic        RST;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_func;
    logic [1:0]  in_ww;
    logic [4:0]  in_rd;
    logic [2:0]  in_ppp;
    logic [63:0] in_a;
    logic [63:0] in_b;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [4:0]  out_rd;
    logic [2:0]  out_ppp;
    logic        out_err;

    typedef struct packed {
        logic [63:0] d;
        logic [4:0]  rd;
        logic [2:0]  ppp;
        logic        err;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 CLK = ~CLK;

    vec_alu_pipe #(.DATA_W(64), .OUT_SKID(1)) dut (
        .CLK(CLK), .RST(RST), .in_valid(in_valid), .in_ready(in_ready),
        .in_func(in_func), .in_ww(in_ww), .in_rd(in_rd), .in_ppp(in_ppp),
        .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_rd(out_rd), .out_ppp(out_ppp), .out_err(out_err)
    );

    task automatic check(input string name, input logic [72:0] act, input logic [72:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the transfer.
    task automatic send(input logic [3:0] f, input logic [1:0] ww, input logic [4:0] rd,
                        input logic [2:0] ppp, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp_d, input logic exp_e);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_func  = f;
        in_ww    = ww;
        in_rd    = rd;
        in_ppp   = ppp;
        in_a     = a;
        in_b     = b;
        while (!in_ready && n < 200) begin
            @(negedge CLK);
            n++;
        end
        check($sformatf("accept rd=%0d", rd), 73'(in_ready), 73'd1);
        if (in_ready)
            q.push_back('{d: exp_d, rd: rd, ppp: ppp, err: exp_e});
        @(negedge CLK);
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 100) begin
            @(negedge CLK);
            n++;
        end
        @(negedge CLK);
        check("drain", 73'(q.size()), 73'd0);
    endtask

    initial begin
        exp_t e;
        exp_t hv;
        logic held;
        held = 1'b0;
        forever begin
            @(negedge CLK);
            #1;
            if (RST) begin
                held = 1'b0;
                continue;
            end
            if (held) begin
                check("stall_valid", 73'(out_valid), 73'd1);
                check("stall_hold", {out_data, out_rd, out_ppp, out_err}, hv);
            end
            if (out_valid && out_ready) begin
                held = 1'b0;
                if (q.size() == 0) begin
                    check("spurious_out", 73'(out_valid), 73'd0);
                end else begin
                    e = q.pop_front();
                    check($sformatf("out rd=%0d", e.rd), {out_data, out_rd, out_ppp, out_err}, e);
                end
            end else if (out_valid) begin
                held = 1'b1;
                hv   = {out_data, out_rd, out_ppp, out_err};
            end else begin
                held = 1'b0;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        RST       = 1'b1;
        in_valid  = 1'b1;
        in_func   = 4'h5;
        in_ww     = 2'b00;
        in_rd     = 5'd9;
        in_ppp    = 3'd0;
        in_a      = '1;
        in_b      = '1;
        out_ready = 1'b1;
        repeat (2) begin
            @(negedge CLK);
            check("rst_out_valid", 73'(out_valid), 73'd0);
            check("rst_out_data", 73'(out_data), 73'd0);
            check("rst_in_ready", 73'(in_ready), 73'd0);
        end
        RST      = 1'b0;
        in_valid = 1'b0;
        #1 check("in_ready_after_rst", 73'(in_ready), 73'd1);
        repeat (4) @(negedge CLK);

        send(4'h5, 2'b00, 5'd1, 3'd0, 64'hFF01FF01FF01FF01, 64'h0101010101010101, 64'h0002000200020002, 1'b0);
        check("lat_cycle1", 73'(out_valid), 73'd0);
        @(negedge CLK);
        check("lat_cycle2", 73'(out_valid), 73'd1);

        send(4'hE, 2'b01, 5'd2, 3'd1, 64'h8000800080008000, 64'h0004000400040004, 64'hF800F800F800F800, 1'b0);
        send(4'hD, 2'b01, 5'd3, 3'd2, 64'h8000800080008000, 64'h0000000000000004, 64'h0800080008000800, 1'b0);
        send(4'h7, 2'b10, 5'd4, 3'd3, 64'hFFFFFFFF00000000, 64'h0000000200000000, 64'h00000001FFFFFFFE, 1'b0);
        send(4'h7, 2'b11, 5'd5, 3'd4, 64'hFFFFFFFF00000000, 64'h0000000200000000, 64'h0, 1'b1);
`ifdef VEC_ALU_SAT_EN
        send(4'h5, 2'b00, 5'd6, 3'b100, 64'hF0F0F0F0F0F0F0F0, 64'h2020202020202020, 64'hFFFFFFFFFFFFFFFF, 1'b0);
`else
        send(4'h5, 2'b00, 5'd6, 3'b100, 64'hF0F0F0F0F0F0F0F0, 64'h2020202020202020, 64'h1010101010101010, 1'b0);
`endif
        send(4'h0, 2'b11, 5'd7, 3'd5, 64'hF0F0F0F00F0F0F0F, 64'hFF00FF00FF00FF00, 64'hF000F0000F000F00, 1'b0);
        send(4'h2, 2'b01, 5'd8, 3'd6, 64'hF0F0F0F00F0F0F0F, 64'hFF00FF00FF00FF00, 64'h0FF00FF0F00FF00F, 1'b0);
        send(4'h3, 2'b10, 5'd9, 3'd7, 64'h0123456789ABCDEF, 64'h0, 64'hFEDCBA9876543210, 1'b0);
        send(4'h6, 2'b10, 5'd10, 3'd0, 64'h0000000500000000, 64'h0000000200000001, 64'h00000003FFFFFFFF, 1'b0);
        send(4'h9, 2'b01, 5'd11, 3'd1, 64'h12345678ABCDEF01, 64'h0, 64'h34127856CDAB01EF, 1'b0);
        send(4'hA, 2'b00, 5'd12, 3'd2, 64'h0101010101010101, 64'h0001020304050607, 64'h0102040810204080, 1'b0);
        send(4'h8, 2'b00, 5'd13, 3'd3, 64'h0102030405060708, 64'h0003000500070009, 64'h00060014002A0048, 1'b0);
        send(4'hF, 2'b11, 5'd14, 3'd4, 64'h8000000000000010, 64'hFFFFFFFFFFFFFFC4, 64'hF800000000000001, 1'b0);
        wait_drain();

        send(4'h4, 2'b00, 5'd30, 3'd7, 64'hDEADBEEFDEADBEEF, 64'h0, 64'hDEADBEEFDEADBEEF, 1'b0);
        RST = 1'b1;
        q.delete();
        @(negedge CLK);
        check("rst_mid_out_valid", 73'(out_valid), 73'd0);
        RST = 1'b0;
        repeat (6) @(negedge CLK);

        fork
            for (int i = 1; i <= 8; i++)
                send(4'h5, 2'b11, 5'(i), 3'(i), 64'h1000 * i, 64'(i), 64'h1001 * i, 1'b0);
            begin
                repeat (3) @(posedge CLK);
                #2 out_ready = 1'b0;
                repeat (4) @(posedge CLK);
                #2 out_ready = 1'b1;
            end
        join
        wait_drain();
        repeat (4) @(negedge CLK);
        check("queue_empty", 73'(q.size()), 73'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
